// File: rtl/midi_voice_alloc.sv
// Polyphonic MIDI voice allocator: note-on/off and All-Notes-Off for one channel.
// Free voices are filled lowest-first; when all are sounding, the least-recently-used one is stolen.
module midi_voice_alloc #(
  parameter int NUM_VOICES = 4,
  localparam int VW = $clog2(NUM_VOICES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [3:0]                chan_sel,
  input  logic                      cmd_valid,
  input  logic [7:0]                byte1,
  input  logic [7:0]                byte2,
  input  logic [7:0]                byte3,
  output logic                      cmd_ready,
  output logic [NUM_VOICES-1:0]     gen,
  output logic [7*NUM_VOICES-1:0]   note_out,
  output logic [7*NUM_VOICES-1:0]   velocity_out,
  output logic                      voice_upd,
  output logic [VW-1:0]             upd_voice,
  output logic                      stolen
);

  typedef enum logic [1:0] {IDLE, MATCH, COMMIT} state_t;
  typedef enum logic [1:0] {ACT_NONE, ACT_LOAD, ACT_OFF, ACT_ALLOFF} act_t;

  state_t                state_q, state_d;
  logic [3:0]            stat_q, stat_d;
  logic                  ok_q, ok_d;
  logic [6:0]            b2_q, b2_d;
  logic [6:0]            b3_q, b3_d;
  act_t                  act_q, act_d;
  logic [VW-1:0]         tgt_q, tgt_d;
  logic                  steal_q, steal_d;
  logic [NUM_VOICES-1:0] mask_q, mask_d;
  logic [NUM_VOICES-1:0] gen_q, gen_d;
  logic [6:0]            note_q [NUM_VOICES];
  logic [6:0]            note_d [NUM_VOICES];
  logic [6:0]            vel_q  [NUM_VOICES];
  logic [6:0]            vel_d  [NUM_VOICES];
  logic [VW-1:0]         rank_q [NUM_VOICES];
  logic [VW-1:0]         rank_d [NUM_VOICES];
  logic                  upd_q, upd_d;
  logic [VW-1:0]         upd_voice_q, upd_voice_d;
  logic                  stolen_q, stolen_d;

  logic                  hit, free_hit;
  logic [VW-1:0]         hit_idx, free_idx, lru_idx;
  logic [NUM_VOICES-1:0] hit_mask;
  logic                  note_on, note_off, all_off;

  // Data-byte MSBs carry no information in MIDI data bytes.
  logic unused_msbs;
  assign unused_msbs = byte2[7] ^ byte3[7];

  // Reverse scan so the lowest index wins among equal candidates.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_mask = '0;
    free_hit = 1'b0;
    free_idx = '0;
    lru_idx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (gen_q[i] && (note_q[i] == b2_q)) begin
        hit         = 1'b1;
        hit_idx     = VW'(i);
        hit_mask[i] = 1'b1;
      end
      if (!gen_q[i]) begin
        free_hit = 1'b1;
        free_idx = VW'(i);
      end
      if (rank_q[i] == '0) begin
        lru_idx = VW'(i);
      end
    end
  end

  assign note_on  = (stat_q == 4'h9) && (b3_q != '0);
  assign note_off = (stat_q == 4'h8) || ((stat_q == 4'h9) && (b3_q == '0));
  assign all_off  = (stat_q == 4'hB) && (b2_q == 7'd123);

  always_comb begin
    state_d     = state_q;
    stat_d      = stat_q;
    ok_d        = ok_q;
    b2_d        = b2_q;
    b3_d        = b3_q;
    act_d       = act_q;
    tgt_d       = tgt_q;
    steal_d     = steal_q;
    mask_d      = mask_q;
    gen_d       = gen_q;
    note_d      = note_q;
    vel_d       = vel_q;
    rank_d      = rank_q;
    upd_d       = 1'b0;
    upd_voice_d = upd_voice_q;
    stolen_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = MATCH;
          stat_d  = byte1[7:4];
          ok_d    = en && (byte1[3:0] == chan_sel);
          b2_d    = byte2[6:0];
          b3_d    = byte3[6:0];
        end
      end
      MATCH: begin
        state_d = COMMIT;
        act_d   = ACT_NONE;
        tgt_d   = '0;
        steal_d = 1'b0;
        mask_d  = '0;
        if (ok_q) begin
          if (note_on) begin
            act_d = ACT_LOAD;
            if (hit) begin
              tgt_d = hit_idx;
            end else if (free_hit) begin
              tgt_d = free_idx;
            end else begin
              tgt_d   = lru_idx;
              steal_d = 1'b1;
            end
          end else if (note_off && hit) begin
            act_d  = ACT_OFF;
            tgt_d  = hit_idx;
            mask_d = hit_mask;
          end else if (all_off) begin
            act_d = ACT_ALLOFF;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (act_q != ACT_NONE) begin
          upd_d       = 1'b1;
          upd_voice_d = tgt_q;
          stolen_d    = steal_q;
        end
        case (act_q)
          ACT_LOAD: begin
            note_d[tgt_q] = b2_q;
            vel_d[tgt_q]  = b3_q;
            gen_d[tgt_q]  = 1'b1;
            for (int j = 0; j < NUM_VOICES; j++) begin
              if (rank_q[j] > rank_q[tgt_q]) begin
                rank_d[j] = rank_q[j] - VW'(1);
              end
            end
            rank_d[tgt_q] = VW'(NUM_VOICES - 1);
          end
          ACT_OFF:    gen_d = gen_q & ~mask_q;
          ACT_ALLOFF: gen_d = '0;
          default:    ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      stat_q      <= '0;
      ok_q        <= 1'b0;
      b2_q        <= '0;
      b3_q        <= '0;
      act_q       <= ACT_NONE;
      tgt_q       <= '0;
      steal_q     <= 1'b0;
      mask_q      <= '0;
      gen_q       <= '0;
      upd_q       <= 1'b0;
      upd_voice_q <= '0;
      stolen_q    <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        rank_q[i] <= VW'(i);
      end
    end else begin
      state_q     <= state_d;
      stat_q      <= stat_d;
      ok_q        <= ok_d;
      b2_q        <= b2_d;
      b3_q        <= b3_d;
      act_q       <= act_d;
      tgt_q       <= tgt_d;
      steal_q     <= steal_d;
      mask_q      <= mask_d;
      gen_q       <= gen_d;
      note_q      <= note_d;
      vel_q       <= vel_d;
      rank_q      <= rank_d;
      upd_q       <= upd_d;
      upd_voice_q <= upd_voice_d;
      stolen_q    <= stolen_d;
    end
  end

  always_comb begin
    note_out     = '0;
    velocity_out = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      note_out[7*i +: 7]     = note_q[i];
      velocity_out[7*i +: 7] = vel_q[i];
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign gen       = gen_q;
  assign voice_upd = upd_q;
  assign upd_voice = upd_voice_q;
  assign stolen    = stolen_q;

endmodule
